// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multicycle R-type MIPS core.
// Field positions, opcode/funct codes and the FSM state encoding.
package mips_pkg;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_DONE
    } state_e;

endpackage

// File: rtl/mips_alu_p.sv
// mips_alu_p: combinational R-type ALU with signed-overflow and unknown-funct flags.
module mips_alu_p
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    output logic [DATA_W-1:0] result_o,
    output logic              overflow_o,
    output logic              illegal_o
);
    localparam int M = DATA_W - 1;
    logic [DATA_W-1:0] sum, diff;
    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        illegal_o  = 1'b0;
        case (funct_i)
            F_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
            end
            F_ADDU: result_o = sum;
            F_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[M] != b_i[M]) && (diff[M] != a_i[M]);
            end
            F_SUBU: result_o = diff;
            F_AND:  result_o = a_i & b_i;
            F_OR:   result_o = a_i | b_i;
            F_XOR:  result_o = a_i ^ b_i;
            F_NOR:  result_o = ~(a_i | b_i);
            F_SLT:  result_o = DATA_W'($signed(a_i) < $signed(b_i));
            F_SLTU: result_o = DATA_W'(a_i < b_i);
            F_SLL:  result_o = b_i << shamt_i;
            F_SRL:  result_o = b_i >> shamt_i;
            F_SRA:  result_o = $signed(b_i) >>> shamt_i;
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle R-type MIPS core, IDLE->DECODE->EXEC->DONE, register file inside.
// Macro MIPS_CORE_OVF_TRAP_EN: add/sub signed overflow raises overflow and suppresses the rd write.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instruction,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result,
    output logic              illegal,
    output logic              overflow
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e            state_q, state_d;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] a_q, b_q, result_q, alu_y;
    logic              illegal_q, alu_ovf, alu_bad, ovf_trap, bad, wr_en;
    logic [4:0]        rs, rt, rd;

    assign rs = instr_q[RS_MSB:RS_LSB];
    assign rt = instr_q[RT_MSB:RT_LSB];
    assign rd = instr_q[RD_MSB:RD_LSB];

    mips_alu_p #(.DATA_W(DATA_W)) u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .shamt_i    (instr_q[SHAMT_MSB:SHAMT_LSB]),
        .funct_i    (instr_q[FUNCT_MSB:FUNCT_LSB]),
        .result_o   (alu_y),
        .overflow_o (alu_ovf),
        .illegal_o  (alu_bad)
    );

    assign bad = (instr_q[OPC_MSB:OPC_LSB] != OP_RTYPE) | alu_bad
               | (int'(rs) >= NUM_REGS) | (int'(rt) >= NUM_REGS) | (int'(rd) >= NUM_REGS);

`ifdef MIPS_CORE_OVF_TRAP_EN
    logic overflow_q;
    assign ovf_trap = alu_ovf & ~bad;
    always_ff @(posedge clk) begin
        if (!rst_n)
            overflow_q <= 1'b0;
        else if (state_q == S_EXEC)
            overflow_q <= ovf_trap;
    end
    assign overflow = overflow_q;
`else
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
    assign ovf_trap   = 1'b0;
    assign overflow   = 1'b0;
`endif

    // $0 is never written, so its reset value of zero makes it read as 0.
    assign wr_en = (state_q == S_EXEC) & ~bad & ~ovf_trap & (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = instr_valid ? S_DECODE : S_IDLE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_DONE;
            default:  state_d = result_ready ? S_IDLE : S_DONE;
        endcase
    end

    always_comb begin
        instr_ready  = (state_q == S_IDLE);
        result_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                rf_q[i] <= DATA_W'(i);
        end else begin
            if (state_q == S_IDLE && instr_valid)
                instr_q <= instruction;
            if (state_q == S_DECODE) begin
                a_q <= rf_q[rs[IDX_W-1:0]];
                b_q <= rf_q[rt[IDX_W-1:0]];
            end
            if (state_q == S_EXEC) begin
                result_q  <= bad ? '0 : alu_y;
                illegal_q <= bad;
            end
            if (wr_en)
                rf_q[rd[IDX_W-1:0]] <= alu_y;
        end
    end

    assign result  = result_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed + randomized checks against a behavioural register/ALU model.
// Expectations follow MIPS_CORE_OVF_TRAP_EN when it is defined for the build.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst_n, instr_valid, instr_ready, result_valid, result_ready;
    logic        illegal, overflow;
    logic [31:0] instruction, result;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] mrf [32];

    always #5 clk = ~clk;

    mips_multicycle_core #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .illegal      (illegal),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] f, input int s, input int t, input int d, input int sh);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), f};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = i;
    endtask

    // Architectural model: computes the result with plain integer arithmetic and commits rd.
    task automatic model(input logic [31:0] ins, output logic [31:0] r, output logic ill, output logic ov);
        int unsigned a, b;
        int          sa, sb, sh, d;
        longint      s;
        logic [5:0]  f;
        f  = ins[5:0];
        sh = int'(ins[10:6]);
        d  = int'(ins[15:11]);
        a  = mrf[ins[25:21]];
        b  = mrf[ins[20:16]];
        sa = a;
        sb = b;
        r  = 0;
        ov = 0;
        ill = (ins[31:26] != 6'd0);
        case (f)
            6'h20, 6'h21: begin
                r = a + b;
                s = longint'(sa) + longint'(sb);
                ov = (f == 6'h20) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            6'h22, 6'h23: begin
                r = a - b;
                s = longint'(sa) - longint'(sb);
                ov = (f == 6'h22) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = (sa < sb) ? 1 : 0;
            6'h2B: r = (a < b) ? 1 : 0;
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = sb >>> sh;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            r  = 0;
            ov = 0;
        end
`ifndef MIPS_CORE_OVF_TRAP_EN
        ov = 0;
`endif
        if (!ill && !ov && d != 0) mrf[d] = r;
    endtask

    task automatic issue(input logic [31:0] ins, input int stall);
        logic [31:0] er;
        logic        ei, eo;
        int          lat;
        model(ins, er, ei, eo);
        @(negedge clk);
        chk("ready", instr_ready, 1);
        instr_valid = 1'b1;
        instruction = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instruction = $urandom();
        lat = 0;
        while (!result_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 2);
        chk("result", result, er);
        chk("illegal", illegal, ei);
        chk("overflow", overflow, eo);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_vld", result_valid, 1);
            chk("hold_rdy", instr_ready, 0);
            chk("hold_res", result, er);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("back_idle", instr_ready, 1);
        chk("vld_drop", result_valid, 0);
    endtask

    task automatic readback(input int r);
        issue(enc(6'h21, r, 0, 0, 0), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", result_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_rdy", instr_ready, 1);
    endtask

    // Reset lands while the instruction sits in EXEC, so its write must be lost.
    task automatic abort_in_exec(input logic [31:0] ins);
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_vld", result_valid, 0);
        chk("abort_res", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("abort_rdy", instr_ready, 1);
    endtask

    logic [5:0] functs [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        result_ready = 1'b0;
        model_reset();
        do_reset();
        issue(32'h00221820, 0);
        readback(3);
        issue(32'h00222022, 0);
        readback(4);
        issue(32'h00072900, 5);
        readback(5);
        issue(32'h000147C0, 0);
        issue(32'h01014822, 0);
        readback(9);
        issue(32'h20000000, 0);
        issue(enc(6'h3F, 1, 2, 6, 0), 1);
        readback(6);
        issue(32'h00221820, 0);
        abort_in_exec(32'h00421820);
        readback(3);
        abort_in_exec(32'h00221820);
        readback(3);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            ins = enc(functs[$urandom_range(0, 12)], $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(1, 31), $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) ins[5:0] = 6'($urandom());
            if ($urandom_range(0, 15) == 0) ins[31:26] = 6'($urandom_range(1, 63));
            issue(ins, $urandom_range(0, 2));
        end
        for (int r = 0; r < 32; r++) readback(r);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
